seq_detector_param: RTL



---
 rtl/seq_detector_param.sv | 84 ++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Runtime-programmable serial sequence detector with a
//               registered (Moore) match flag and a saturating match counter.
//               Overlapping or non-overlapping detection chosen at elaboration.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int unsigned      PAT_W   = 4,        // legal range 2..32
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,  // MSB is the oldest bit
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic [PAT_W-1:0] pattern
);

    // fill counts 0..PAT_W, so it needs one value beyond PAT_W-1
    localparam int unsigned      c_FILL_W  = $clog2(PAT_W + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_W-1:0]    r_pat;
    logic [PAT_W-1:0]    r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic                r_y;
    logic [CNT_W-1:0]    r_cnt;

    logic [PAT_W-1:0]    w_hist_n;
    logic [c_FILL_W-1:0] w_fill_n;
    logic                w_match;

    // Next history/fill for an accepted sample, and the match decision.
    // A pattern load on the same edge discards the sample, so it can never match.
    always_comb begin
        w_hist_n = {r_hist[PAT_W-2:0], x};
        w_fill_n = (r_fill == c_FILL_FULL) ? r_fill : r_fill + c_FILL_W'(1);
        w_match  = en && !pat_load && (w_fill_n == c_FILL_FULL) && (w_hist_n == r_pat);
    end

    // Pattern, history, fill level and match flag; load takes priority over sampling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat  <= PATTERN;
            r_hist <= '0;
            r_fill <= '0;
            r_y    <= 1'b0;
        end else if (pat_load) begin
            r_pat  <= pat_in;
            r_hist <= '0;
            r_fill <= '0;
            r_y    <= 1'b0;
        end else if (en) begin
            r_hist <= w_hist_n;
            r_y    <= w_match;
            // Non-overlapping mode forgets history so the next match needs PAT_W new bits
            r_fill <= (w_match && !OVERLAP) ? '0 : w_fill_n;
        end
    end

    // Saturating match counter; clear beats a coincident increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign y           = r_y;
    assign match_count = r_cnt;
    assign pattern     = r_pat;

endmodule
`default_nettype wire
